// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared widths, command type and peripheral addresses for the system data bus
// Purpose: common definitions imported by cmd_fifo, bus_master and their benches.
//   ADDR_W/DATA_W : bus address and data widths
//   cmd_t         : one queued load/store command {we, addr, wdata}
//   LEDS/SWS/BTNS : register addresses of the LED/switch/button controller
package bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam logic [ADDR_W-1:0] LEDS = 16'h0000;
  localparam logic [ADDR_W-1:0] SWS  = 16'h0002;
  localparam logic [ADDR_W-1:0] BTNS = 16'h0004;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command FIFO of cmd_t entries
// Purpose: buffers commands between the core and the bus issue stage.
// Ports:
//   sys_clk, sys_rst_n : clock, synchronous active-low reset (flushes contents)
//   push, push_data    : write one entry (ignored when full)
//   pop                : drop the head entry (ignored when empty)
//   head               : current head entry, valid while !empty
//   count, full, empty : occupancy status
module cmd_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     push,
  input  cmd_t                     push_data,
  input  logic                     pop,
  output cmd_t                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so wrap-around on a power-of-2 depth is free.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_master.sv
// rtl/bus_master.sv - initiator of the 16-bit system data bus with command FIFO and read pipeline
// Purpose: queues load/store commands, issues one registered bus cycle per command and
//          returns read data in issue order, two cycles after the read's bus cycle.
// Ports:
//   sys_clk, sys_rst_n        : clock, synchronous active-low reset
//   cmd_valid/cmd_ready       : command handshake; cmd_we/cmd_addr/cmd_wdata carry the command
//   issue_en                  : 0 halts issuing, the FIFO keeps accepting
//   rsp_valid/rsp_rdata       : one-cycle read response strobe and held read data
//   busy                      : commands queued or a read still in flight
//   bus_a/bus_do/bus_we/bus_di: registered bus outputs and peripheral read data
module bus_master
  import bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              issue_en,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] bus_a,
  output logic [DATA_W-1:0] bus_do,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_di
);

  cmd_t                 head;
  cmd_t                 push_data;
  logic [$clog2(DEPTH):0] count;
  logic                 full;
  logic                 empty;
  logic                 ready_q;
  logic                 push;
  logic                 pop;
  logic                 rd_v0;   // read on the bus this cycle
  logic                 rd_v1;   // peripheral's registered data on bus_di this cycle

  // ready_q keeps cmd_ready low while reset is held, high from the first cycle after release.
  assign cmd_ready = ready_q && !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = issue_en && !empty;
  assign push_data = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
  assign busy      = (count != '0) || rd_v0 || rd_v1;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ready_q   <= 1'b0;
      bus_a     <= '0;
      bus_do    <= '0;
      bus_we    <= 1'b0;
      rd_v0     <= 1'b0;
      rd_v1     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      ready_q <= 1'b1;
      bus_we  <= pop && head.we;
      rd_v0   <= pop && !head.we;
      // Address and write data hold between commands; reads leave bus_do untouched.
      if (pop) begin
        bus_a <= head.addr;
        if (head.we) begin
          bus_do <= head.wdata;
        end
      end
      rd_v1     <= rd_v0;
      rsp_valid <= rd_v1;
      if (rd_v1) begin
        rsp_rdata <= bus_di;
      end
    end
  end

endmodule
